// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the datapath width.
package alu_pkg;

  localparam int unsigned ALU_W = 16;

  // Opcodes: bit 1 selects subtract (invert B), ADC/SBC take carry-in from the carry flag.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_ADC = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SBC = 2'b11;

  // Bit positions inside the 4-bit {Z,N,C,V} flag vector.
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_add16_cin.sv
// Combinational ripple-carry adder built from a full-adder chain, with carry-in.
// Ports:
//   a, b  : operands
//   cin   : carry into bit 0
//   sum   : W-bit sum
//   cout  : carry out of the top bit
module alu_add16_cin #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/alu_add16_stage.sv
// Registered ADD/ADC/SUB/SBC stage around the 16-bit ripple adder.
// One-cycle latency, valid/ready on both sides, persistent carry flag for multi-word chains.
// Optional build macro ALU_ADD_SAT_EN: saturating results (ADD/ADC clamp to 0xFFFF on carry,
// SUB/SBC clamp to 0x0000 on borrow); C and carry_q still record the raw carry.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : request handshake
//   in_op, in_a, in_b    : opcode and operands
//   c_load, c_value      : direct write of the carry flag (wins over an accept's carry)
//   out_valid/out_ready  : result handshake
//   out_data, out_flags  : registered result and {Z,N,C,V}
//   carry_q              : current carry flag
module alu_add16_stage
  import alu_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned OPW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           c_load,
  input  logic           c_value,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [3:0]     out_flags,
  output logic           carry_q
);

  if (W != ALU_W) begin : g_bad_width
    $error("alu_add16_stage: W must be 16");
  end

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic [3:0]   out_flags_q;
  logic         carry_flag_q;

  logic         accept;
  logic [W-1:0] b_eff;
  logic         cin;
  logic [W-1:0] sum;
  logic         c16;
  logic         ovf;
  logic [W-1:0] res_d;
  logic [3:0]   flags_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign b_eff = in_op[1] ? ~in_b : in_b;

  always_comb begin
    cin = 1'b0;
    unique case (in_op)
      ALU_ADD: cin = 1'b0;
      ALU_ADC: cin = carry_flag_q;
      ALU_SUB: cin = 1'b1;
      ALU_SBC: cin = carry_flag_q;
      default: cin = 1'b0;
    endcase
  end

  alu_add16_cin #(
    .W (W)
  ) u_adder (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (c16)
  );

  // Signed overflow: operands agree in sign but the result does not.
  assign ovf = (in_a[W-1] == b_eff[W-1]) && (sum[W-1] != in_a[W-1]);

  always_comb begin
    res_d   = sum;
    flags_d = 4'b0000;
`ifdef ALU_ADD_SAT_EN
    // Add overflows on carry out; subtract underflows when there is a borrow (c16 == 0).
    if (in_op[1] ? !c16 : c16) begin
      res_d          = in_op[1] ? '0 : '1;
      flags_d[FLG_V] = 1'b0;
    end else begin
      flags_d[FLG_V] = ovf;
    end
`else
    flags_d[FLG_V] = ovf;
`endif
    flags_d[FLG_Z] = (res_d == '0);
    flags_d[FLG_N] = res_d[W-1];
    flags_d[FLG_C] = c16;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_flags_q  <= 4'b0000;
      carry_flag_q <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_d;
        out_flags_q <= flags_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A direct load overrides the carry produced by a same-cycle accept.
      if (c_load) begin
        carry_flag_q <= c_value;
      end else if (accept) begin
        carry_flag_q <= c16;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign carry_q   = carry_flag_q;

endmodule

// File: tb/tb_alu_add16_stage.sv
module tb_alu_add16_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        c_load;
  logic        c_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_flags;
  logic        carry_q;

  always #5 clk = ~clk;

  alu_add16_stage #(
    .W   (16),
    .OPW (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .c_load    (c_load),
    .c_value   (c_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .carry_q   (carry_q)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: {carry, flags[3:0], data[15:0]}.
  logic [20:0] sb_q[$];
  logic        m_valid = 1'b0;
  logic        m_cq    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model written in plain integer arithmetic.
  function automatic logic [20:0] model(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cq);
    int          r;
    int          borrow;
    logic [15:0] s;
    logic        c;
    logic        v;
    if (!op[1]) begin
      r = int'(a) + int'(b) + ((op == ALU_ADC) ? int'(cq) : 0);
      s = r[15:0];
      c = (r > 65535);
      v = (a[15] == b[15]) && (s[15] != a[15]);
`ifdef ALU_ADD_SAT_EN
      if (c) begin s = 16'hFFFF; v = 1'b0; end
`endif
    end else begin
      borrow = (op == ALU_SBC) ? int'(!cq) : 0;
      r = int'(a) - int'(b) - borrow;
      s = r[15:0];
      c = (int'(a) >= int'(b) + borrow);
      v = (a[15] != b[15]) && (s[15] != a[15]);
`ifdef ALU_ADD_SAT_EN
      if (!c) begin s = 16'h0000; v = 1'b0; end
`endif
    end
    return {c, (s == 16'h0), s[15], c, v, s};
  endfunction

  // One clock: drive after the edge, check and update the model at the falling edge.
  task automatic step(input bit v, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input bit ordy, input bit cl, input bit cv);
    logic        exp_ready;
    logic        acc;
    logic        consume;
    logic [20:0] e;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    c_load    = cl;
    c_value   = cv;
    @(negedge clk);
    exp_ready = !m_valid || ordy;
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, m_valid);
    check_eq("carry_q", carry_q, m_cq);
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_nonempty", 0, 1);
      end else begin
        check_eq("out_data", out_data, sb_q[0][15:0]);
        check_eq("out_flags", out_flags, sb_q[0][19:16]);
      end
    end
    acc     = v && exp_ready;
    consume = m_valid && ordy;
    if (consume && sb_q.size() > 0) void'(sb_q.pop_front());
    e = model(op, a, b, m_cq);
    if (acc) sb_q.push_back(e);
    if (cl) m_cq = cv;
    else if (acc) m_cq = e[20];
    if (acc) m_valid = 1'b1;
    else if (consume) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, ALU_ADD, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = ALU_ADD;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    c_load    = 1'b0;
    c_value   = 1'b0;
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_flags", out_flags, 0);
    check_eq("rst_carry_q", carry_q, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", in_ready, 1);

    // 1: plain ADD
    step(1'b1, ALU_ADD, 16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b0);
    check_eq("t1_data", out_data, 16'h2233);
    check_eq("t1_flags", out_flags, 4'b0000);
    idle();

    // 2: wrap-around then chained ADC
    step(1'b1, ALU_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    check_eq("t2_data", out_data, 16'h0000);
    check_eq("t2_flags", out_flags, 4'b1010);
    step(1'b1, ALU_ADC, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("t2_adc_data", out_data, 16'h0001);
    check_eq("t2_adc_flags", out_flags, 4'b0000);
    idle();

    // 3: SUB with signed overflow, then SBC with a borrow pending
    step(1'b1, ALU_SUB, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check_eq("t3_sub_data", out_data, 16'h7FFF);
    check_eq("t3_sub_flags", out_flags, 4'b0011);
    step(1'b0, ALU_ADD, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, ALU_SBC, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("t3_sbc_data", out_data, 16'hFFFF);
    check_eq("t3_sbc_flags", out_flags, 4'b0100);
    idle();

    // 4: stall with a request waiting, then accept+consume in one cycle
    step(1'b1, ALU_ADD, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ALU_SUB, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b0);
      check_eq("t4_stall_data", out_data, 16'h0030);
    end
    step(1'b1, ALU_SUB, 16'h0100, 16'h0001, 1'b1, 1'b0, 1'b0);
    check_eq("t4_replace_valid", out_valid, 1);
    check_eq("t4_replace_data", out_data, 16'h00FF);
    idle();

    // 5: c_load beats the accept's carry; the op itself used the old carry
    step(1'b1, ALU_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b1);
    check_eq("t5_flag_c", out_flags[FLG_C], 1);
    check_eq("t5_carry_q", carry_q, 1);
    step(1'b1, ALU_ADC, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
    check_eq("t5_adc_data", out_data, 16'h0003);
    idle();

    // 6: asynchronous reset while stalled
    step(1'b1, ALU_ADD, 16'h0005, 16'h0006, 1'b0, 1'b1, 1'b1);
    step(1'b0, ALU_ADD, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_out_valid", out_valid, 0);
    check_eq("t6_out_data", out_data, 0);
    check_eq("t6_out_flags", out_flags, 0);
    check_eq("t6_carry_q", carry_q, 0);
    #1 rst = 1'b0;
    m_valid = 1'b0;
    m_cq    = 1'b0;
    sb_q.delete();
    idle();

`ifdef ALU_ADD_SAT_EN
    step(1'b1, ALU_ADD, 16'hF000, 16'h2000, 1'b1, 1'b0, 1'b0);
    check_eq("sat_data", out_data, 16'hFFFF);
    check_eq("sat_flags", out_flags, 4'b0110);
    step(1'b1, ALU_SUB, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0);
    check_eq("sat_sub_data", out_data, 16'h0000);
    idle();
`endif

    // Random traffic with random backpressure and carry loads.
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           16'($urandom), 16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
